// File: rtl/pipe_stall_ctrl.sv
// Pipeline sequencing controller: per-stage stall vector, flush strobe,
// multi-cycle execute counter and fetch-wait watchdog.
module pipe_stall_ctrl #(
  parameter int unsigned CNT_W    = 6,
  parameter int unsigned WDOG_MAX = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stallreq_if,
  input  logic             stallreq_id,
  input  logic             ex_mc_start,
  input  logic [CNT_W-1:0] ex_mc_cycles,
  input  logic             flush_req,
  output logic [5:0]       stall,
  output logic             flush,
  output logic             ex_busy,
  output logic             mc_last,
  output logic             if_timeout
);

  localparam int unsigned WdogW = (WDOG_MAX > 1) ? $clog2(WDOG_MAX) : 1;

  localparam logic [5:0] StallMc = 6'b001111;
  localparam logic [5:0] StallId = 6'b000111;
  localparam logic [5:0] StallIf = 6'b000011;

  typedef enum logic [0:0] {StIdle, StMulti} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [WdogW-1:0]   wdog_q, wdog_d;
  logic               if_timeout_q, if_timeout_d;
  logic [5:0]         stall_raw;
  logic               flush_raw, mc_last_raw;

  always_comb begin
    stall_raw   = '0;
    flush_raw   = 1'b0;
    mc_last_raw = 1'b0;
    state_d     = state_q;
    count_d     = count_q;
    if (flush_req) begin
      flush_raw = 1'b1;
      state_d   = StIdle;
      count_d   = '0;
    end else if (state_q == StMulti) begin
      stall_raw   = StallMc;
      count_d     = count_q - CNT_W'(1);
      mc_last_raw = (count_q == CNT_W'(1));
      if (count_q == CNT_W'(1)) state_d = StIdle;
    end else if (ex_mc_start) begin
      stall_raw = StallMc;
      // Lengths 0 and 1 both mean a single stall cycle with no MULTI phase.
      if (ex_mc_cycles <= CNT_W'(1)) begin
        mc_last_raw = 1'b1;
      end else begin
        state_d = StMulti;
        count_d = ex_mc_cycles - CNT_W'(1);
      end
    end else if (stallreq_id) begin
      stall_raw = StallId;
    end else if (stallreq_if) begin
      stall_raw = StallIf;
    end
  end

  // Watchdog counts raw fetch requests even when a higher-priority stall masks them.
  always_comb begin
    wdog_d       = '0;
    if_timeout_d = 1'b0;
    if (stallreq_if && !flush_req) begin
      if (wdog_q == WdogW'(WDOG_MAX - 1)) begin
        if_timeout_d = 1'b1;
      end else begin
        wdog_d = wdog_q + WdogW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      count_q      <= '0;
      wdog_q       <= '0;
      if_timeout_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      wdog_q       <= wdog_d;
      if_timeout_q <= if_timeout_d;
    end
  end

  // Outputs are forced low for the whole reset assertion, not just after the edge.
  always_comb begin
    stall   = rst ? 6'b0 : stall_raw;
    flush   = rst ? 1'b0 : flush_raw;
    mc_last = rst ? 1'b0 : mc_last_raw;
  end

  assign ex_busy    = (state_q == StMulti);
  assign if_timeout = if_timeout_q;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed self-checking bench for pipe_stall_ctrl.
module tb_pipe_stall_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       stallreq_if, stallreq_id, ex_mc_start, flush_req;
  logic [5:0] ex_mc_cycles;
  logic [5:0] stall;
  logic       flush, ex_busy, mc_last, if_timeout;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pipe_stall_ctrl #(.CNT_W(6), .WDOG_MAX(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .stallreq_if  (stallreq_if),
    .stallreq_id  (stallreq_id),
    .ex_mc_start  (ex_mc_start),
    .ex_mc_cycles (ex_mc_cycles),
    .flush_req    (flush_req),
    .stall        (stall),
    .flush        (flush),
    .ex_busy      (ex_busy),
    .mc_last      (mc_last),
    .if_timeout   (if_timeout)
  );

  // Inputs change 1 time unit after the rising edge; checks happen at the falling edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    stallreq_if = 1'b0; stallreq_id = 1'b0; ex_mc_start = 1'b0;
    flush_req = 1'b0; ex_mc_cycles = 6'd0;
    @(negedge clk);
    ex_mc_start = 1'b1; flush_req = 1'b1; stallreq_id = 1'b1;
    #1;
    total++;
    if ({stall, flush, ex_busy, mc_last, if_timeout} !== 10'b0) begin
      bad++;
      $display("FAIL reset_outputs: got stall=%b flush=%b busy=%b last=%b to=%b, want all 0",
               stall, flush, ex_busy, mc_last, if_timeout);
    end
    ex_mc_start = 1'b0; flush_req = 1'b0; stallreq_id = 1'b0;
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    total++;
    if ({stall, flush, ex_busy, mc_last, if_timeout} !== 10'b0) begin
      bad++;
      $display("FAIL post_reset_idle: got stall=%b flush=%b busy=%b last=%b, want all 0",
               stall, flush, ex_busy, mc_last);
    end
  endtask

  task automatic test_multi();
    next_cycle();
    ex_mc_start = 1'b1; ex_mc_cycles = 6'd5;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      total++;
      if (stall !== ((c <= 5) ? 6'b001111 : 6'b000000) || ex_busy !== (c >= 2 && c <= 5) ||
          mc_last !== (c == 5)) begin
        bad++;
        $display("FAIL multi5_cycle%0d: got stall=%b busy=%b last=%b", c, stall, ex_busy,
                 mc_last);
      end
      next_cycle();
      ex_mc_start = 1'b0;
    end
  endtask

  task automatic test_edge_lengths();
    for (int n = 0; n <= 1; n++) begin
      ex_mc_start = 1'b1; ex_mc_cycles = 6'(n);
      for (int r = 0; r < 2; r++) begin
        @(negedge clk);
        total++;
        if (stall !== 6'b001111 || mc_last !== 1'b1 || ex_busy !== 1'b0) begin
          bad++;
          $display("FAIL edge_n%0d_start%0d: got stall=%b last=%b busy=%b, want 001111 1 0",
                   n, r, stall, mc_last, ex_busy);
        end
        next_cycle();
      end
      ex_mc_start = 1'b0;
      @(negedge clk);
      total++;
      if (stall !== 6'b0 || ex_busy !== 1'b0 || mc_last !== 1'b0) begin
        bad++;
        $display("FAIL edge_n%0d_after: got stall=%b busy=%b last=%b, want 0", n, stall,
                 ex_busy, mc_last);
      end
      next_cycle();
    end
  endtask

  task automatic test_flush_abort();
    ex_mc_start = 1'b1; ex_mc_cycles = 6'd8;
    next_cycle();
    ex_mc_start = 1'b0;
    next_cycle();
    flush_req = 1'b1; ex_mc_start = 1'b1;
    @(negedge clk);
    total++;
    if (flush !== 1'b1 || stall !== 6'b0 || mc_last !== 1'b0 || ex_busy !== 1'b1) begin
      bad++;
      $display("FAIL flush_cycle: got flush=%b stall=%b last=%b busy=%b, want 1 000000 0 1",
               flush, stall, mc_last, ex_busy);
    end
    next_cycle();
    flush_req = 1'b0; ex_mc_start = 1'b0;
    @(negedge clk);
    total++;
    if (flush !== 1'b0 || stall !== 6'b0 || ex_busy !== 1'b0) begin
      bad++;
      $display("FAIL flush_after: got flush=%b stall=%b busy=%b, want 0 000000 0", flush, stall,
               ex_busy);
    end
    next_cycle();
  endtask

  task automatic test_priority();
    logic [5:0] exp_stall [5];
    exp_stall[0] = 6'b001111; exp_stall[1] = 6'b001111; exp_stall[2] = 6'b001111;
    exp_stall[3] = 6'b000111; exp_stall[4] = 6'b000011;
    stallreq_if = 1'b1; stallreq_id = 1'b1; ex_mc_start = 1'b1; ex_mc_cycles = 6'd3;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      total++;
      if (stall !== exp_stall[c] || mc_last !== (c == 2)) begin
        bad++;
        $display("FAIL priority_cycle%0d: got stall=%b last=%b, want %b %b", c + 1, stall,
                 mc_last, exp_stall[c], (c == 2));
      end
      next_cycle();
      ex_mc_start = 1'b0;
      if (c == 3) stallreq_id = 1'b0;
    end
    stallreq_if = 1'b0;
    next_cycle();
  endtask

  task automatic test_reset_mid_multi();
    ex_mc_start = 1'b1; ex_mc_cycles = 6'd10;
    next_cycle();
    ex_mc_start = 1'b0;
    next_cycle();
    next_cycle();
    rst = 1'b1;
    #1;
    total++;
    if (stall !== 6'b0 || ex_busy !== 1'b0 || mc_last !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid_multi: got stall=%b busy=%b last=%b, want 0", stall, ex_busy,
               mc_last);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 2; c++) begin
      next_cycle();
      @(negedge clk);
      total++;
      if (stall !== 6'b0 || ex_busy !== 1'b0) begin
        bad++;
        $display("FAIL reset_release_%0d: got stall=%b busy=%b, want 0 0", c, stall, ex_busy);
      end
    end
    next_cycle();
  endtask

  task automatic test_watchdog();
    int pulses;
    int pulse_cycle;
    pulses = 0; pulse_cycle = 0;
    stallreq_if = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (if_timeout === 1'b1) begin
        pulses++;
        pulse_cycle = c;
      end
      next_cycle();
    end
    total++;
    if (pulses != 1 || pulse_cycle != 33) begin
      bad++;
      $display("FAIL wdog_hold40: got pulses=%0d at cycle %0d, want 1 at cycle 33", pulses,
               pulse_cycle);
    end
    stallreq_if = 1'b0;
    next_cycle();
    next_cycle();
    pulses = 0; pulse_cycle = 0;
    stallreq_if = 1'b1;
    for (int c = 1; c <= 60; c++) begin
      flush_req = (c == 20);
      @(negedge clk);
      if (c == 20) begin
        total++;
        if (flush !== 1'b1 || stall !== 6'b0) begin
          bad++;
          $display("FAIL wdog_flush_cycle: got flush=%b stall=%b, want 1 000000", flush, stall);
        end
      end
      if (if_timeout === 1'b1) begin
        pulses++;
        pulse_cycle = c;
      end
      next_cycle();
    end
    flush_req = 1'b0; stallreq_if = 1'b0;
    total++;
    if (pulses != 1 || pulse_cycle != 53) begin
      bad++;
      $display("FAIL wdog_flush_rerun: got pulses=%0d at cycle %0d, want 1 at cycle 53", pulses,
               pulse_cycle);
    end
    next_cycle();
  endtask

  initial begin
    test_reset();
    test_multi();
    test_edge_lengths();
    test_flush_abort();
    test_priority();
    test_reset_mid_multi();
    test_watchdog();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
